// File: rtl/instruction_fetch.sv
// Instruction fetch stage: walks a word-addressed PC through instruction memory and hands
// one registered instruction at a time to decode over a valid/ready handshake.
//
// Ports:
//   clk            - sole clock, all state updates on the rising edge
//   rst_n          - synchronous active-low reset
//   inst_addr      - word address to instruction memory (always the current pc)
//   inst_rdata     - instruction word returned combinationally for inst_addr
//   redirect_valid - branch/jump redirect request, overrides capture and stall
//   redirect_addr  - redirect target word address
//   out_valid      - out_inst/out_pc hold an instruction for decode
//   out_ready      - decode accepts the instruction this cycle
//   out_inst       - registered fetched instruction
//   out_pc         - word address of out_inst
//   fault          - a fetch was attempted at an address >= MEM_SIZE (sticky until redirect)
//   fetch_count    - instructions captured since reset, wraps at 2^32
module instruction_fetch #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           MEM_SIZE   = 1024,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] inst_addr,
    input  logic [DATA_WIDTH-1:0] inst_rdata,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_inst,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic                  fault,
    output logic [31:0]           fetch_count
);

    typedef enum logic [1:0] {StIdle, StFetch, StHalt} state_e;

    // One extra bit so MEM_SIZE == 2^ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_SIZE);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_inst_q, out_inst_d;
    logic [ADDR_WIDTH-1:0]   out_pc_q, out_pc_d;
    logic                    fault_q, fault_d;
    logic [31:0]             fetch_count_q, fetch_count_d;

    logic pc_in_range;
    logic can_advance;
    logic capture;

    // The output register is free when empty or being drained this cycle.
    assign pc_in_range = {1'b0, pc_q} < MEM_LIMIT;
    assign can_advance = !out_valid_q || out_ready;
    assign capture     = (state_q == StFetch) && !redirect_valid && can_advance && pc_in_range;

    // State register and datapath flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            pc_q          <= RESET_PC;
            out_valid_q   <= 1'b0;
            out_inst_q    <= '0;
            out_pc_q      <= '0;
            fault_q       <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            out_valid_q   <= out_valid_d;
            out_inst_q    <= out_inst_d;
            out_pc_q      <= out_pc_d;
            fault_q       <= fault_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  state_d = StFetch;
            StFetch: begin
                // Running off the end only halts once the output slot is free.
                if (!redirect_valid && can_advance && !pc_in_range) begin
                    state_d = StHalt;
                end
            end
            StHalt: begin
                if (redirect_valid) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath next values.
    always_comb begin
        pc_d          = pc_q;
        out_valid_d   = out_valid_q;
        out_inst_d    = out_inst_q;
        out_pc_d      = out_pc_q;
        fault_d       = fault_q;
        fetch_count_d = fetch_count_q;

        if (redirect_valid) begin
            // Flush whatever is in flight, even if decode has not taken it.
            pc_d        = redirect_addr;
            out_valid_d = 1'b0;
            fault_d     = 1'b0;
        end else if (capture) begin
            out_inst_d    = inst_rdata;
            out_pc_d      = pc_q;
            out_valid_d   = 1'b1;
            pc_d          = pc_q + ADDR_WIDTH'(1);
            fetch_count_d = fetch_count_q + 32'd1;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            if ((state_q == StFetch) && can_advance && !pc_in_range) begin
                fault_d = 1'b1;
            end
        end
    end

    // Outputs.
    always_comb begin
        inst_addr   = pc_q;
        out_valid   = out_valid_q;
        out_inst    = out_inst_q;
        out_pc      = out_pc_q;
        fault       = fault_q;
        fetch_count = fetch_count_q;
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch. A small DUT (4-bit PC, 4 valid words) runs
// directed scenarios and then randomized reset/redirect/ready traffic, checked every cycle
// against a behavioural model. A second DUT (2-bit PC, full 4-word space, RESET_PC=2)
// checks PC wrap-around.
module tb_instruction_fetch;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned MS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [AW-1:0] inst_addr;
    logic [DW-1:0] inst_rdata;
    logic          redirect_valid;
    logic [AW-1:0] redirect_addr;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_inst;
    logic [AW-1:0] out_pc;
    logic          fault;
    logic [31:0]   fetch_count;

    logic          w_rst_n;
    logic [1:0]    w_inst_addr;
    logic [DW-1:0] w_inst_rdata;
    logic          w_out_valid;
    logic [DW-1:0] w_out_inst;
    logic [1:0]    w_out_pc;
    logic          w_fault;
    logic [31:0]   w_fetch_count;

    int n_vec  = 0;
    int n_miss = 0;

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        case (a)
            4'd0:    return 32'h34D78131;
            4'd1:    return 32'h0AC510D1;
            default: return 32'hC0DE0000 ^ ({28'b0, a} * 32'h01010101);
        endcase
    endfunction

    assign inst_rdata   = mem_word(inst_addr);
    assign w_inst_rdata = mem_word({2'b00, w_inst_addr});

    instruction_fetch #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .MEM_SIZE  (MS),
        .RESET_PC  (4'd0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .inst_addr     (inst_addr),
        .inst_rdata    (inst_rdata),
        .redirect_valid(redirect_valid),
        .redirect_addr (redirect_addr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_inst      (out_inst),
        .out_pc        (out_pc),
        .fault         (fault),
        .fetch_count   (fetch_count)
    );

    instruction_fetch #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(2),
        .MEM_SIZE  (4),
        .RESET_PC  (2'd2)
    ) dut_wrap (
        .clk           (clk),
        .rst_n         (w_rst_n),
        .inst_addr     (w_inst_addr),
        .inst_rdata    (w_inst_rdata),
        .redirect_valid(1'b0),
        .redirect_addr (2'd0),
        .out_valid     (w_out_valid),
        .out_ready     (1'b1),
        .out_inst      (w_out_inst),
        .out_pc        (w_out_pc),
        .fault         (w_fault),
        .fetch_count   (w_fetch_count)
    );

    // Behavioural model of the main DUT. m_mode: 0 idle bubble, 1 fetching, 2 halted.
    int          m_mode;
    logic [AW-1:0] m_pc;
    logic        m_valid;
    logic [31:0] m_inst;
    logic [AW-1:0] m_opc;
    logic        m_fault;
    logic [31:0] m_cnt;

    task automatic model_step(input logic rst, input logic redir, input logic [AW-1:0] raddr,
                              input logic rdy);
        bit room;
        if (!rst) begin
            m_mode = 0; m_pc = 4'd0; m_valid = 0; m_inst = 0; m_opc = 0; m_fault = 0;
            m_cnt = 0;
        end else if (redir) begin
            m_pc = raddr; m_valid = 0; m_fault = 0; m_mode = 1;
        end else begin
            room = !m_valid || rdy;
            if (m_mode == 1 && room && int'(m_pc) < MS) begin
                m_inst = mem_word(m_pc);
                m_opc  = m_pc;
                m_valid = 1;
                m_pc   = m_pc + 4'd1;
                m_cnt  = m_cnt + 1;
            end else if (m_mode == 1 && room) begin
                m_mode = 2; m_fault = 1; m_valid = 0;
            end else begin
                if (m_valid && rdy) m_valid = 0;
                if (m_mode == 0) m_mode = 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_inst", out_inst, m_inst);
        chk("out_pc", 32'(out_pc), 32'(m_opc));
        chk("fault", 32'(fault), 32'(m_fault));
        chk("fetch_count", fetch_count, m_cnt);
        chk("inst_addr", 32'(inst_addr), 32'(m_pc));
    endtask

    task automatic tick(input logic rst, input logic redir, input logic [AW-1:0] raddr,
                        input logic rdy);
        rst_n = rst; redirect_valid = redir; redirect_addr = raddr; out_ready = rdy;
        @(posedge clk);
        model_step(rst, redir, raddr, rdy);
        #1;
        compare_all();
    endtask

    initial begin
        w_rst_n = 1'b0;
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_addr", 32'(inst_addr), 32'd0);

        // Release: one idle bubble, then back-to-back captures.
        w_rst_n = 1'b1;
        tick(1, 0, 0, 1);
        chk("idle_bubble", 32'(out_valid), 32'd0);
        tick(1, 0, 0, 1);
        chk("first_inst", out_inst, 32'h34D78131);
        chk("first_pc", 32'(out_pc), 32'd0);
        tick(1, 0, 0, 1);
        chk("second_inst", out_inst, 32'h0AC510D1);
        chk("second_pc", 32'(out_pc), 32'd1);
        chk("count2", fetch_count, 32'd2);
        chk("wrap_pc3", 32'(w_out_pc), 32'd3);
        chk("wrap_addr0", 32'(w_inst_addr), 32'd0);

        // Stall with out_ready low.
        repeat (3) begin
            tick(1, 0, 0, 0);
            chk("stall_pc", 32'(out_pc), 32'd1);
            chk("stall_addr", 32'(inst_addr), 32'd2);
            chk("stall_valid", 32'(out_valid), 32'd1);
        end
        chk("wrap_pc2", 32'(w_out_pc), 32'd2);
        chk("wrap_count", w_fetch_count, 32'd5);
        chk("wrap_fault", 32'(w_fault), 32'd0);
        tick(1, 0, 0, 1);
        chk("unstall_pc", 32'(out_pc), 32'd2);

        // Redirect flushes a stalled instruction.
        tick(1, 1, 4'd0, 0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_addr", 32'(inst_addr), 32'd0);
        tick(1, 0, 0, 0);
        chk("redir_pc", 32'(out_pc), 32'd0);
        chk("redir_inst", out_inst, 32'h34D78131);

        // Run off the end of memory.
        for (int i = 1; i < 4; i++) begin
            tick(1, 0, 0, 1);
            chk("tail_pc", 32'(out_pc), 32'(i));
        end
        tick(1, 0, 0, 1);
        chk("halt_fault", 32'(fault), 32'd1);
        chk("halt_valid", 32'(out_valid), 32'd0);
        chk("halt_addr", 32'(inst_addr), 32'd4);
        tick(1, 0, 0, 1);
        chk("halt_hold", 32'(inst_addr), 32'd4);
        chk("halt_count", fetch_count, 32'd7);
        tick(1, 1, 4'd1, 1);
        chk("unhalt_fault", 32'(fault), 32'd0);
        tick(1, 0, 0, 1);
        chk("unhalt_pc", 32'(out_pc), 32'd1);
        chk("unhalt_valid", 32'(out_valid), 32'd1);

        // Reset beats redirect mid-stall.
        tick(1, 0, 0, 0);
        tick(0, 1, 4'd3, 0);
        chk("rst_stall_valid", 32'(out_valid), 32'd0);
        chk("rst_stall_count", fetch_count, 32'd0);
        chk("rst_stall_addr", 32'(inst_addr), 32'd0);
        chk("rst_stall_fault", 32'(fault), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic          r_rst;
            logic          r_redir;
            logic [AW-1:0] r_addr;
            logic          r_rdy;
            r_rst   = ($urandom_range(0, 49) != 0);
            r_redir = ($urandom_range(0, 9) == 0);
            r_addr  = AW'($urandom_range(0, 15));
            r_rdy   = ($urandom_range(0, 9) < 7);
            tick(r_rst, r_redir, r_addr, r_rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
